// File: rtl/digit_scanner_pkg.sv
// digit_scanner_pkg: shared widths, defaults and the blank digit-select level.
package digit_scanner_pkg;
  localparam int DIGIT_W = 4;
  localparam int NUM_DIGITS_DEFAULT = 8;
  localparam logic SEG_OFF = 1'b1;
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v == lim) ? v : v + 4'd1;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler that pulses tick once every CLK_DIV enabled cycles.
module tick_gen #(
  parameter int CLK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt;
  assign tick = en && (cnt == W'(CLK_DIV - 1));
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else if (tick) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/digit_scanner.sv
// digit_scanner: shift-register digit buffer scanned onto a multiplexed display.
module digit_scanner
  import digit_scanner_pkg::*;
#(
  parameter int CLK_DIV    = 100000,
  parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  push,
  input  logic [DIGIT_W-1:0]    push_digit,
  input  logic                  clear,
  output logic [DIGIT_W-1:0]    key,
  output logic [NUM_DIGITS-1:0] seg_en,
  output logic [3:0]            count,
  output logic                  full
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  logic [DIGIT_W-1:0] slots [NUM_DIGITS];
  logic [IW-1:0]      idx;
  logic               tick;
  logic               active;
  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );
  assign full   = (count == 4'(NUM_DIGITS));
  assign active = int'(idx) < int'(count);
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) slots[i] <= '0;
      count <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) slots[i] <= '0;
      count <= '0;
    end else if (push) begin
      slots[0] <= push_digit;
      for (int i = 1; i < NUM_DIGITS; i++) slots[i] <= slots[i-1];
      count <= sat_inc(count, 4'(NUM_DIGITS));
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) idx <= '0;
    else if (tick) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
  end
  // key holds its last value while disabled so the decoder input stays stable
  always_ff @(posedge clk) begin
    if (!rst) begin
      key    <= '0;
      seg_en <= {NUM_DIGITS{SEG_OFF}};
    end else if (en) begin
      key    <= slots[idx];
      seg_en <= active ? ~(NUM_DIGITS'(1) << idx) : {NUM_DIGITS{SEG_OFF}};
    end else begin
      seg_en <= {NUM_DIGITS{SEG_OFF}};
    end
  end
endmodule

// File: tb/tb_digit_scanner.sv
// tb_digit_scanner: directed table-driven checks of digit_scanner with CLK_DIV=4, NUM_DIGITS=8.
module tb_digit_scanner;
  logic       clk = 1'b0;
  logic       rst, en, push, clear;
  logic [3:0] push_digit;
  logic [3:0] key;
  logic [7:0] seg_en;
  logic [3:0] count;
  logic       full;
  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [3:0] digit;
    logic [3:0] cnt;
    logic       full;
  } pv_t;

  pv_t        tbl [10];
  logic [3:0] ek [8];

  digit_scanner #(.CLK_DIV(4), .NUM_DIGITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .push       (push),
    .push_digit (push_digit),
    .clear      (clear),
    .key        (key),
    .seg_en     (seg_en),
    .count      (count),
    .full       (full)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic do_push(input logic [3:0] d);
    push = 1'b1;
    push_digit = d;
    cyc();
    push = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic wait_seg(input logic [7:0] v, input string name);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (seg_en == v) begin
        ok = 1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  // one full rotation is 32 cycles: each shown index must appear for exactly 4 of them
  task automatic scan_check(input logic [3:0] exp_key [8], input int n, input string name);
    int hits [8];
    int blank = 0;
    int odd = 0;
    int wrong = 0;
    int found;
    for (int j = 0; j < 8; j++) hits[j] = 0;
    for (int c = 0; c < 32; c++) begin
      cyc();
      if (seg_en == 8'hFF) blank++;
      else begin
        found = -1;
        for (int j = 0; j < 8; j++) if (seg_en == ~(8'b1 << j)) found = j;
        if (found < 0 || found >= n) odd++;
        else begin
          hits[found]++;
          if (key !== exp_key[found]) wrong++;
        end
      end
    end
    chk({name, "_blank"}, 32'(blank), 32'(32 - 4 * n));
    chk({name, "_odd"}, 32'(odd), 32'd0);
    chk({name, "_key"}, 32'(wrong), 32'd0);
    for (int j = 0; j < n; j++) chk({name, "_hits"}, 32'(hits[j]), 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int errs;
    int n;
    logic [3:0] k0;
    for (int i = 0; i < 10; i++) begin
      tbl[i].digit = 4'(i);
      tbl[i].cnt   = (i < 8) ? 4'(i + 1) : 4'd8;
      tbl[i].full  = (i >= 7);
    end
    rst = 1'b0; en = 1'b0; push = 1'b0; clear = 1'b0; push_digit = 4'd0;
    cyc(); cyc();
    chk("rst_key", 32'(key), 32'd0);
    chk("rst_seg", 32'(seg_en), 32'hFF);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    rst = 1'b1; en = 1'b1;

    errs = 0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      if (seg_en !== 8'hFF || count !== 4'd0) errs++;
    end
    chk("empty_scan", 32'(errs), 32'd0);

    do_push(4'd3); do_push(4'd7); do_push(4'd1);
    chk("three_count", 32'(count), 32'd3);
    ek = '{4'd1, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    scan_check(ek, 3, "three");

    do_clear();
    push = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_digit = tbl[i].digit;
      cyc();
      chk("fill_count", 32'(count), 32'(tbl[i].cnt));
      chk("fill_full", 32'(full), 32'(tbl[i].full));
    end
    push = 1'b0;
    ek = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2};
    scan_check(ek, 8, "full");

    do_clear();
    for (int i = 0; i < 4; i++) do_push(4'(i + 2));
    chk("pre_clr_count", 32'(count), 32'd4);
    clear = 1'b1; push = 1'b1; push_digit = 4'd5;
    cyc();
    clear = 1'b0; push = 1'b0;
    chk("clr_push_count", 32'(count), 32'd0);
    chk("clr_push_full", 32'(full), 32'd0);
    cyc();
    chk("clr_push_seg", 32'(seg_en), 32'hFF);
    ek = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    scan_check(ek, 0, "cleared");
    do_push(4'hC);
    ek[0] = 4'hC;
    scan_check(ek, 1, "hex_digit");

    do_clear();
    for (int i = 1; i <= 6; i++) do_push(4'(i));
    wait_seg(8'hDF, "wait_idx5");
    chk("idx5_key", 32'(key), 32'd1);
    en = 1'b0;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      push = (i == 5);
      push_digit = 4'd7;
      cyc();
      if (seg_en !== 8'hFF || key !== 4'd1) errs++;
    end
    push = 1'b0;
    chk("en_low_hold", 32'(errs), 32'd0);
    chk("en_low_count", 32'(count), 32'd7);
    en = 1'b1;
    n = 0;
    k0 = 4'hX;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (seg_en != 8'hDF) break;
      if (n == 0) k0 = key;
      n++;
    end
    chk("resume_len", 32'(n), 32'd3);
    chk("resume_key5", 32'(k0), 32'd2);
    chk("resume_seg6", 32'(seg_en), 32'hBF);
    chk("resume_key6", 32'(key), 32'd1);

    do_push(4'd8);
    chk("pre_rst_full", 32'(full), 32'd1);
    wait_seg(8'hBF, "wait_idx6");
    rst = 1'b0; push = 1'b1; clear = 1'b0; push_digit = 4'd9;
    cyc();
    push = 1'b0; rst = 1'b1;
    chk("mid_rst_key", 32'(key), 32'd0);
    chk("mid_rst_seg", 32'(seg_en), 32'hFF);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_full", 32'(full), 32'd0);
    do_push(4'hF);
    chk("post_rst_count", 32'(count), 32'd1);
    cyc();
    chk("post_rst_seg", 32'(seg_en), 32'hFE);
    chk("post_rst_key", 32'(key), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/digit_scanner.md
DIGIT_SCANNER -- requirements
Module: digit_scanner

Interface
REQ-001 Parameter: CLK_DIV, default 100000, clock cycles per scan step (>=2).
REQ-002 Parameter: NUM_DIGITS, default 8, number of digit slots and seg_en width.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-low.
REQ-005 Port: en  input  1  scan enable; low blanks the display and freezes scanning.
REQ-006 Port: push  input  1  one-cycle strobe; loads push_digit into the buffer.
REQ-007 Port: push_digit  input  4  decoded digit value to store.
REQ-008 Port: clear  input  1  one-cycle strobe; empties the buffer.
REQ-009 Port: key  output  4  registered value of the currently scanned digit.
REQ-010 Port: seg_en  output  NUM_DIGITS  registered active-low one-hot digit select.
REQ-011 Port: count  output  4  number of valid digits, 0..NUM_DIGITS.
REQ-012 Port: full  output  1  high when count == NUM_DIGITS.

Function
REQ-013 The buffer SHALL be a NUM_DIGITS x 4-bit shift register; slot 0 holds the newest digit.
REQ-014 On push, slot 0 SHALL take push_digit and slot i SHALL take slot i-1; the old top slot is discarded.
REQ-015 count SHALL increment on push, saturating at NUM_DIGITS; push when full SHALL still shift (oldest digit lost).
REQ-016 push_digit values 10..15 SHALL be stored unmodified.
REQ-017 On clear, all slots SHALL become 0 and count SHALL become 0; clear with push in the same cycle SHALL apply clear only.
REQ-018 A prescaler SHALL count 0..CLK_DIV-1 while en is high and SHALL emit a one-cycle tick at CLK_DIV-1, then wrap to 0.
REQ-019 The scan index SHALL advance on each tick, 0..NUM_DIGITS-1, wrapping to 0.
REQ-020 One cycle after each clk edge, key SHALL equal slot[index] and seg_en SHALL equal ~(1<<index) if index < count, else all ones.
REQ-021 Latency: a push SHALL be visible on key/seg_en no later than the first registered update after the push (1 cycle if slot 0 is being scanned).
REQ-022 While en is low, the prescaler and index SHALL hold, seg_en SHALL be all ones, and key SHALL hold its last value; push and clear SHALL still act.
REQ-023 When en rises, scanning SHALL resume from the held index and prescaler values.
REQ-024 count == 0 SHALL give seg_en all ones at every index.

Reset
REQ-025 When rst is low at a clk edge, the block SHALL set all slots, count, index and prescaler to 0, key to 0 and seg_en to all ones.
REQ-026 Reset SHALL override push, clear and en in the same cycle, and an in-progress scan SHALL restart from index 0.
REQ-027 full SHALL be 0 after reset.

Structure
REQ-028 The shared package SHALL hold DIGIT_W = 4, NUM_DIGITS default 8, and SEG_OFF = all-ones blank pattern.
REQ-029 The prescaler SHALL be one sub-module, tick_gen, with ports clk, rst, en, tick, parameterised by CLK_DIV.
REQ-030 key SHALL drive the downstream 7-segment decoder's digit input, and seg_en its digit-enable input, unmodified.

Verification (CLK_DIV = 4, NUM_DIGITS = 8)
REQ-031 Reset, then en=1, no push -> seg_en = 8'hFF for 64 cycles and count = 0.
REQ-032 Push 3, 7, 1 -> count = 3; index 0 gives key = 1, seg_en = 8'hFE; index 1 gives key = 7, seg_en = 8'hFD; index 2 gives key = 3, seg_en = 8'hFB; index 3..7 give seg_en = 8'hFF; ticks every 4 cycles.
REQ-033 Push 0..9 (10 pushes) -> count = 8, full = 1; slots 0..7 = 9,8,7,6,5,4,3,2.
REQ-034 clear and push (digit 5) in the same cycle while count = 4 -> count = 0, all slots 0, seg_en = 8'hFF.
REQ-035 en dropped at index 5 for 20 cycles -> seg_en = 8'hFF and index holds at 5; push during this window -> count increments; after en rises, the next tick moves index to 6.
REQ-036 rst low mid-scan at index 6 with count 8 -> next cycle key = 0, seg_en = 8'hFF, count = 0, index = 0.
